cfg_loader: RTL and testbench

- Configuration bitstream loader feeding the head of the fabric's programming shift chain: IO blocks, CLBs and other configurable cells.
- Accepts configuration bytes over a valid/ready handshake and serialises them MSB-first onto prog_in.
- Generates prog_clk as a divided strobe from the system clock.
- Frames the load with prog_en; the falling edge of prog_en is the commit that makes every cell transfer its shifted bits into live control.

---
 rtl/cfg_loader_if.sv | 20 ++
 rtl/cfg_loader.sv | 190 +++++++++++++++++++
 tb/tb_cfg_loader.sv | 298 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cfg_loader_if.sv
// Configuration byte stream: valid/ready handshake carrying one byte per transfer.
interface cfg_loader_if;
    logic [7:0] cfg_data;
    logic       cfg_valid;
    logic       cfg_ready;

    // Byte source (software/DMA side).
    modport master (
        output cfg_data,
        output cfg_valid,
        input  cfg_ready
    );

    // Byte sink (the loader).
    modport slave (
        input  cfg_data,
        input  cfg_valid,
        output cfg_ready
    );
endinterface

// File: rtl/cfg_loader.sv
// Configuration bitstream loader: takes bytes over a valid/ready handshake and shifts
// them MSB-first into the fabric programming chain with a divided prog_clk strobe.
// prog_en frames the whole load; its falling edge commits the chain into live control.
module cfg_loader #(
    parameter int unsigned CHAIN_LEN = 3,
    parameter int unsigned CLK_DIV   = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic         abort,
    cfg_loader_if.slave  cfg,
    output logic         prog_in,
    output logic         prog_clk,
    output logic         prog_en,
    output logic         busy,
    output logic         done,
    output logic         err
);

    localparam int unsigned BW = $clog2(CHAIN_LEN + 1);
    localparam int unsigned DW = $clog2(CLK_DIV + 1);

    localparam logic [BW-1:0] LAST_BIT = BW'(CHAIN_LEN - 1);
    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

    localparam logic [2:0] StIdle    = 3'd0;
    localparam logic [2:0] StFetch   = 3'd1;
    localparam logic [2:0] StShiftLo = 3'd2;
    localparam logic [2:0] StShiftHi = 3'd3;
    localparam logic [2:0] StCommit  = 3'd4;
    localparam logic [2:0] StAborted = 3'd5;

    logic [2:0]    state_q, state_d;
    logic [BW-1:0] bit_cnt_q, bit_cnt_d;
    logic [DW-1:0] div_q, div_d;
    logic [2:0]    byte_bit_q, byte_bit_d;
    // Bits still to be shifted from the current byte; its MSB already sits on prog_in.
    logic [6:0]    shreg_q, shreg_d;
    logic          ready_q, ready_d;
    logic          prog_in_q, prog_in_d;
    logic          prog_clk_q, prog_clk_d;
    logic          prog_en_q, prog_en_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          err_q, err_d;

    logic load_active;

    assign load_active = (state_q == StFetch) || (state_q == StShiftLo) ||
                         (state_q == StShiftHi) || (state_q == StCommit);

    // Next-state logic for the load sequencer and all registered outputs.
    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        div_d      = div_q;
        byte_bit_d = byte_bit_q;
        shreg_d    = shreg_q;
        ready_d    = ready_q;
        prog_in_d  = prog_in_q;
        prog_clk_d = prog_clk_q;
        prog_en_d  = prog_en_q;
        busy_d     = busy_q;
        done_d     = done_q;
        err_d      = err_q;

        case (state_q)
            StIdle, StAborted: begin
                if (start) begin
                    // From ABORTED prog_en is already high and stays high: no commit edge.
                    state_d    = StFetch;
                    prog_en_d  = 1'b1;
                    prog_clk_d = 1'b0;
                    busy_d     = 1'b1;
                    done_d     = 1'b0;
                    err_d      = 1'b0;
                    bit_cnt_d  = '0;
                    byte_bit_d = '0;
                    div_d      = '0;
                    ready_d    = 1'b1;
                end
            end
            StFetch: begin
                if (cfg.cfg_valid && ready_q) begin
                    prog_in_d = cfg.cfg_data[7];
                    shreg_d   = cfg.cfg_data[6:0];
                    ready_d   = 1'b0;
                    div_d     = '0;
                    state_d   = StShiftLo;
                end
            end
            StShiftLo: begin
                if (div_q == DIV_LAST) begin
                    div_d      = '0;
                    prog_clk_d = 1'b1;
                    state_d    = StShiftHi;
                end else begin
                    div_d = div_q + 1'b1;
                end
            end
            StShiftHi: begin
                if (div_q == DIV_LAST) begin
                    div_d      = '0;
                    prog_clk_d = 1'b0;
                    bit_cnt_d  = bit_cnt_q + 1'b1;
                    byte_bit_d = byte_bit_q + 1'b1;
                    shreg_d    = {shreg_q[5:0], 1'b0};
                    if (bit_cnt_q == LAST_BIT) begin
                        // Unused LSBs of the final byte are simply dropped.
                        state_d = StCommit;
                    end else if (byte_bit_q == 3'd7) begin
                        state_d = StFetch;
                        ready_d = 1'b1;
                    end else begin
                        state_d   = StShiftLo;
                        prog_in_d = shreg_q[6];
                    end
                end else begin
                    div_d = div_q + 1'b1;
                end
            end
            StCommit: begin
                if (div_q == DIV_LAST) begin
                    div_d     = '0;
                    prog_en_d = 1'b0;
                    done_d    = 1'b1;
                    busy_d    = 1'b0;
                    prog_in_d = 1'b0;
                    state_d   = StIdle;
                end else begin
                    div_d = div_q + 1'b1;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        // Abort overrides any in-flight step; prog_en is left high so nothing commits.
        if (abort && load_active) begin
            state_d    = StAborted;
            prog_clk_d = 1'b0;
            ready_d    = 1'b0;
            busy_d     = 1'b0;
            err_d      = 1'b1;
            div_d      = '0;
        end
    end

    // State and output registers, cleared asynchronously.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= StIdle;
            bit_cnt_q  <= '0;
            div_q      <= '0;
            byte_bit_q <= '0;
            shreg_q    <= '0;
            ready_q    <= 1'b0;
            prog_in_q  <= 1'b0;
            prog_clk_q <= 1'b0;
            prog_en_q  <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            div_q      <= div_d;
            byte_bit_q <= byte_bit_d;
            shreg_q    <= shreg_d;
            ready_q    <= ready_d;
            prog_in_q  <= prog_in_d;
            prog_clk_q <= prog_clk_d;
            prog_en_q  <= prog_en_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            err_q      <= err_d;
        end
    end

    assign cfg.cfg_ready = ready_q;
    assign prog_in       = prog_in_q;
    assign prog_clk      = prog_clk_q;
    assign prog_en       = prog_en_q;
    assign busy          = busy_q;
    assign done          = done_q;
    assign err           = err_q;

endmodule

// File: tb/tb_cfg_loader.sv
// Directed bench for cfg_loader: three instances (3/1, 12/2, 16/1 chain/divider)
// share clock and reset; a negedge monitor records prog_clk rises and shifted bits.
module tb_cfg_loader;

    localparam int DIVS [3] = '{1, 2, 1};

    logic clk = 1'b0;
    logic rst = 1'b1;

    logic       start [3];
    logic       abort [3];
    logic       valid [3];
    logic [7:0] data  [3];
    logic       ready [3];
    logic       pin   [3];
    logic       pclk  [3];
    logic       pen   [3];
    logic       busy  [3];
    logic       done  [3];
    logic       err   [3];

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    cfg_loader_if if0 ();
    cfg_loader_if if1 ();
    cfg_loader_if if2 ();

    assign if0.cfg_data  = data[0];
    assign if0.cfg_valid = valid[0];
    assign ready[0]      = if0.cfg_ready;
    assign if1.cfg_data  = data[1];
    assign if1.cfg_valid = valid[1];
    assign ready[1]      = if1.cfg_ready;
    assign if2.cfg_data  = data[2];
    assign if2.cfg_valid = valid[2];
    assign ready[2]      = if2.cfg_ready;

    cfg_loader #(.CHAIN_LEN(3), .CLK_DIV(1)) u_dut0 (
        .clk(clk), .rst(rst), .start(start[0]), .abort(abort[0]), .cfg(if0),
        .prog_in(pin[0]), .prog_clk(pclk[0]), .prog_en(pen[0]),
        .busy(busy[0]), .done(done[0]), .err(err[0])
    );
    cfg_loader #(.CHAIN_LEN(12), .CLK_DIV(2)) u_dut1 (
        .clk(clk), .rst(rst), .start(start[1]), .abort(abort[1]), .cfg(if1),
        .prog_in(pin[1]), .prog_clk(pclk[1]), .prog_en(pen[1]),
        .busy(busy[1]), .done(done[1]), .err(err[1])
    );
    cfg_loader #(.CHAIN_LEN(16), .CLK_DIV(1)) u_dut2 (
        .clk(clk), .rst(rst), .start(start[2]), .abort(abort[2]), .cfg(if2),
        .prog_in(pin[2]), .prog_clk(pclk[2]), .prog_en(pen[2]),
        .busy(busy[2]), .done(done[2]), .err(err[2])
    );

    // Monitor state, sampled on the falling clock edge.
    int          cyc = 0;
    int          rises [3] = '{default: 0};
    logic [31:0] bits [3] = '{default: 0};
    int          hs [3] = '{default: 0};
    int          pen_falls [3] = '{default: 0};
    int          hi_run [3] = '{default: 0};
    int          hi_bad [3] = '{default: 0};
    int          glitch [3] = '{default: 0};
    int          last_fall_cyc [3] = '{default: 0};
    int          pen_fall_cyc [3] = '{default: 0};
    logic        prev_clk [3] = '{default: 1'b0};
    logic        prev_en [3] = '{default: 1'b0};
    logic        prev_in [3] = '{default: 1'b0};

    // Track prog_clk rises, shifted bits, high-phase widths, prog_in stability and handshakes.
    always @(negedge clk) begin
        cyc <= cyc + 1;
        for (int i = 0; i < 3; i++) begin
            prev_clk[i] <= pclk[i];
            prev_en[i]  <= pen[i];
            prev_in[i]  <= pin[i];
            if (pclk[i] === 1'b1 && prev_clk[i] === 1'b0) begin
                rises[i] <= rises[i] + 1;
                bits[i]  <= {bits[i][30:0], pin[i]};
            end
            if (pclk[i] === 1'b1 && prev_clk[i] === 1'b1 && pin[i] !== prev_in[i])
                glitch[i] <= glitch[i] + 1;
            if (pclk[i] === 1'b1) begin
                hi_run[i] <= hi_run[i] + 1;
            end else if (prev_clk[i] === 1'b1) begin
                if (hi_run[i] != DIVS[i] && !rst) hi_bad[i] <= hi_bad[i] + 1;
                hi_run[i]        <= 0;
                last_fall_cyc[i] <= cyc;
            end
            if (pen[i] === 1'b0 && prev_en[i] === 1'b1) begin
                pen_falls[i]    <= pen_falls[i] + 1;
                pen_fall_cyc[i] <= cyc;
            end
            if (valid[i] === 1'b1 && ready[i] === 1'b1) hs[i] <= hs[i] + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] outs(input int i);
        return {25'd0, pin[i], pclk[i], pen[i], ready[i], busy[i], done[i], err[i]};
    endfunction

    task automatic pulse_start(input int i);
        @(posedge clk); #1 start[i] = 1'b1;
        @(posedge clk); #1 start[i] = 1'b0;
    endtask

    task automatic pulse_abort(input int i);
        @(posedge clk); #1 abort[i] = 1'b1;
        @(posedge clk); #1 abort[i] = 1'b0;
    endtask

    task automatic wait_ready(input int i, input string tag);
        logic ok = 1'b0;
        for (int k = 0; k < 500 && !ok; k++) begin
            @(negedge clk); #1;
            if (ready[i] === 1'b1) ok = 1'b1;
        end
        if (!ok) check(tag, 32'(ok), 1);
    endtask

    // Present a byte and hold valid until the loader takes it.
    task automatic send_byte(input int i, input logic [7:0] b, input string tag);
        @(posedge clk); #1;
        data[i]  = b;
        valid[i] = 1'b1;
        wait_ready(i, tag);
        @(posedge clk); #1 valid[i] = 1'b0;
    endtask

    task automatic wait_idle(input int i, input string tag);
        logic ok = 1'b0;
        for (int k = 0; k < 1000 && !ok; k++) begin
            @(negedge clk); #1;
            if (busy[i] === 1'b0) ok = 1'b1;
        end
        check(tag, 32'(ok), 1);
    endtask

    task automatic wait_rises(input int i, input int n, input string tag);
        logic ok = 1'b0;
        for (int k = 0; k < 500 && !ok; k++) begin
            @(negedge clk); #1;
            if (rises[i] >= n) ok = 1'b1;
        end
        check(tag, 32'(ok), 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int          base;
        int          pf;
        int          gap_bad;
        logic        pin0;
        logic        ok;

        for (int i = 0; i < 3; i++) begin
            start[i] = 1'b0;
            abort[i] = 1'b0;
            valid[i] = 1'b0;
            data[i]  = 8'h00;
        end

        // Reset state.
        repeat (3) @(posedge clk);
        #1;
        check("rst_outs0", outs(0), 0);
        check("rst_outs1", outs(1), 0);
        check("rst_outs2", outs(2), 0);
        @(negedge clk) rst = 1'b0;

        // 3-bit chain, divider 1, byte 0xA0 -> bits 1,0,1.
        base = rises[0];
        pulse_start(0);
        check("t1_busy", 32'(busy[0]), 1);
        send_byte(0, 8'hA0, "t1_ready_to");
        wait_idle(0, "t1_idle_to");
        check("t1_rises", 32'(rises[0] - base), 3);
        check("t1_bits", {29'd0, bits[0][2:0]}, 32'h5);
        check("t1_en_fall", 32'(pen_fall_cyc[0] - last_fall_cyc[0]), 1);
        check("t1_outs", outs(0), 32'h02);
        check("t1_hs", 32'(hs[0]), 1);

        // 12-bit chain, divider 2, bytes 0xF0,0x5F -> 1111 0000 0101.
        base = rises[1];
        pulse_start(1);
        send_byte(1, 8'hF0, "t2_ready0_to");
        send_byte(1, 8'h5F, "t2_ready1_to");
        wait_idle(1, "t2_idle_to");
        check("t2_rises", 32'(rises[1] - base), 12);
        check("t2_bits", {20'd0, bits[1][11:0]}, 32'hF05);
        check("t2_hs", 32'(hs[1]), 2);
        check("t2_hi_width", 32'(hi_bad[1]), 0);
        check("t2_outs", outs(1), 32'h02);

        // 16-bit chain with a 10-cycle gap before the second byte.
        base = rises[2];
        pulse_start(2);
        send_byte(2, 8'h3C, "t3_ready0_to");
        wait_ready(2, "t3_gap_ready_to");
        pin0    = pin[2];
        gap_bad = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk); #1;
            if (pclk[2] !== 1'b0 || pen[2] !== 1'b1 || pin[2] !== pin0) gap_bad++;
        end
        check("t3_gap", 32'(gap_bad), 0);
        check("t3_gap_ready", 32'(ready[2]), 1);
        send_byte(2, 8'hC3, "t3_ready1_to");
        wait_idle(2, "t3_idle_to");
        check("t3_rises", 32'(rises[2] - base), 16);
        check("t3_bits", {16'd0, bits[2][15:0]}, 32'h3CC3);
        check("t3_done", 32'(done[2]), 1);

        // Abort after 5 of 16 bits, then restart from ABORTED.
        pf   = pen_falls[2];
        base = rises[2];
        pulse_start(2);
        send_byte(2, 8'hFF, "t4_ready_to");
        wait_rises(2, base + 5, "t4_rise5_to");
        pulse_abort(2);
        repeat (5) @(negedge clk);
        #1;
        check("t4_ab_rises", 32'(rises[2] - base), 5);
        check("t4_ab_outs", {29'd0, pclk[2], pen[2], ready[2]}, 32'h2);
        check("t4_ab_flags", {29'd0, busy[2], done[2], err[2]}, 32'h1);
        base = rises[2];
        pulse_start(2);
        check("t4_rs_flags", {29'd0, busy[2], done[2], err[2]}, 32'h4);
        send_byte(2, 8'h12, "t4_ready0_to");
        send_byte(2, 8'h34, "t4_ready1_to");
        wait_idle(2, "t4_idle_to");
        check("t4_rs_rises", 32'(rises[2] - base), 16);
        check("t4_rs_bits", {16'd0, bits[2][15:0]}, 32'h1234);
        check("t4_rs_flags_end", {29'd0, busy[2], done[2], err[2]}, 32'h2);
        check("t4_en_falls", 32'(pen_falls[2] - pf), 1);

        // Asynchronous reset during a high phase of prog_clk.
        pulse_start(1);
        send_byte(1, 8'hAA, "t5_ready_to");
        ok = 1'b0;
        for (int k = 0; k < 100 && !ok; k++) begin
            @(negedge clk); #1;
            if (pclk[1] === 1'b1) ok = 1'b1;
        end
        check("t5_pre_hi", 32'(pclk[1]), 1);
        #1 rst = 1'b1;
        #1;
        check("t5_rst_now", outs(1), 0);
        start[1] = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("t5_rst_start", outs(1), 0);
        start[1] = 1'b0;
        @(negedge clk) rst = 1'b0;
        base = rises[1];
        pulse_start(1);
        send_byte(1, 8'h96, "t5_ready0_to");
        send_byte(1, 8'hE0, "t5_ready1_to");
        wait_idle(1, "t5_idle_to");
        check("t5_rises", 32'(rises[1] - base), 12);
        check("t5_bits", {20'd0, bits[1][11:0]}, 32'h96E);
        check("t5_outs", outs(1), 32'h02);

        // start while busy and abort while idle have no effect.
        base = rises[0];
        pulse_start(0);
        send_byte(0, 8'h60, "t6_ready_to");
        pulse_start(0);
        wait_idle(0, "t6_idle_to");
        check("t6_rises", 32'(rises[0] - base), 3);
        check("t6_bits", {29'd0, bits[0][2:0]}, 32'h3);
        pulse_abort(0);
        repeat (3) @(negedge clk);
        #1;
        check("t6_idle_abort", outs(0), 32'h02);
        check("t6_rises_after", 32'(rises[0] - base), 3);
        check("t6_glitch", 32'(glitch[0] + glitch[1] + glitch[2]), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
